// File: rtl/pipeline_perf_monitor.sv
// pipeline_perf_monitor: saturating retire-side event counters with snapshot readout
// and a jump-to-self halt detector that freezes counting once the program parks.
module pipeline_perf_monitor #(
    parameter int CNT_W       = 32,
    parameter int HALT_THRESH = 3
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_en,
    input  logic             i_clear,
    input  logic [31:0]      i_pc_debug,
    input  logic             i_insn_vld,
    input  logic             i_ctrl,
    input  logic             i_mispred,
    input  logic             i_snap_req,
    input  logic [2:0]       i_rd_sel,
    output logic             o_snap_vld,
    output logic [CNT_W-1:0] o_rd_data,
    output logic             o_halt,
    output logic [31:0]      o_halt_pc
);
    typedef enum logic {RUN, HALTED} state_t;
    localparam logic [3:0] THRESH = 4'(HALT_THRESH);

    state_t                  state_q, state_d;
    logic [4:0][CNT_W-1:0]   cnt_q, cnt_d, snap_q, snap_d;
    logic [3:0]              rep_q, rep_d;
    logic [31:0]             last_pc_q, last_pc_d, halt_pc_q, halt_pc_d;
    logic                    last_vld_q, last_vld_d, snap_vld_q, snap_vld_d;
    logic [4:0]              inc;

    always_comb begin
        // counter order: cyc, ret, ctl, mis, bub
        inc        = {!i_insn_vld, i_mispred, i_ctrl, i_insn_vld, 1'b1};
        state_d    = state_q;
        cnt_d      = cnt_q;
        rep_d      = rep_q;
        last_pc_d  = last_pc_q;
        last_vld_d = last_vld_q;
        halt_pc_d  = halt_pc_q;
        snap_vld_d = i_snap_req;
        snap_d     = i_snap_req ? cnt_q : snap_q;
        if (i_clear) begin
            cnt_d      = '0;
            rep_d      = '0;
            last_vld_d = 1'b0;
            state_d    = RUN;
        end else if (i_en && state_q == RUN) begin
            for (int k = 0; k < 5; k++)
                cnt_d[k] = (inc[k] && cnt_q[k] != '1) ? cnt_q[k] + 1'b1 : cnt_q[k];
            if (i_insn_vld) begin
                if (last_vld_q && i_pc_debug == last_pc_q) begin
                    rep_d = (rep_q == THRESH) ? rep_q : rep_q + 4'd1;
                end else begin
                    rep_d      = 4'd1;
                    last_pc_d  = i_pc_debug;
                    last_vld_d = 1'b1;
                end
                if (rep_d == THRESH) begin
                    state_d   = HALTED;
                    halt_pc_d = i_pc_debug;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            snap_q     <= '0;
            rep_q      <= '0;
            last_pc_q  <= '0;
            last_vld_q <= 1'b0;
            halt_pc_q  <= '0;
            snap_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            snap_q     <= snap_d;
            rep_q      <= rep_d;
            last_pc_q  <= last_pc_d;
            last_vld_q <= last_vld_d;
            halt_pc_q  <= halt_pc_d;
            snap_vld_q <= snap_vld_d;
        end
    end

    always_comb begin
        case (i_rd_sel)
            3'd0:    o_rd_data = snap_q[0];
            3'd1:    o_rd_data = snap_q[1];
            3'd2:    o_rd_data = snap_q[2];
            3'd3:    o_rd_data = snap_q[3];
            3'd4:    o_rd_data = snap_q[4];
            3'd5:    o_rd_data = halt_pc_q[CNT_W-1:0];
            default: o_rd_data = '0;
        endcase
    end

    assign o_snap_vld = snap_vld_q;
    assign o_halt     = state_q == HALTED;
    assign o_halt_pc  = halt_pc_q;
endmodule

// File: tb/tb_pipeline_perf_monitor.sv
// tb_pipeline_perf_monitor: directed tests of pipeline_perf_monitor; a CNT_W=8 copy
// shares the stimulus to exercise counter saturation.
module tb_pipeline_perf_monitor;
    logic        i_clk = 1'b0, i_reset = 1'b0, i_en = 1'b0, i_clear = 1'b0;
    logic [31:0] i_pc_debug = '0;
    logic        i_insn_vld = 1'b0, i_ctrl = 1'b0, i_mispred = 1'b0, i_snap_req = 1'b0;
    logic [2:0]  i_rd_sel = '0;
    logic        o_snap_vld, o_halt, snap_vld8, halt8;
    logic [31:0] o_rd_data, o_halt_pc, halt_pc8;
    logic [7:0]  rd_data8;
    int          errors = 0, checks = 0;

    pipeline_perf_monitor #(.CNT_W(32), .HALT_THRESH(3)) u_dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_en(i_en), .i_clear(i_clear),
        .i_pc_debug(i_pc_debug), .i_insn_vld(i_insn_vld), .i_ctrl(i_ctrl),
        .i_mispred(i_mispred), .i_snap_req(i_snap_req), .i_rd_sel(i_rd_sel),
        .o_snap_vld(o_snap_vld), .o_rd_data(o_rd_data), .o_halt(o_halt), .o_halt_pc(o_halt_pc));

    pipeline_perf_monitor #(.CNT_W(8), .HALT_THRESH(3)) u_dut8 (
        .i_clk(i_clk), .i_reset(i_reset), .i_en(i_en), .i_clear(i_clear),
        .i_pc_debug(i_pc_debug), .i_insn_vld(i_insn_vld), .i_ctrl(i_ctrl),
        .i_mispred(i_mispred), .i_snap_req(i_snap_req), .i_rd_sel(i_rd_sel),
        .o_snap_vld(snap_vld8), .o_rd_data(rd_data8), .o_halt(halt8), .o_halt_pc(halt_pc8));

    always #5 i_clk = ~i_clk;

    task automatic tick(input logic vld, input logic [31:0] pc, input logic ctl, input logic mis);
        i_insn_vld = vld; i_pc_debug = pc; i_ctrl = ctl; i_mispred = mis;
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic snapshot();
        i_en = 1'b0; i_snap_req = 1'b1;
        tick(1'b0, 32'h0, 1'b0, 1'b0);
        i_snap_req = 1'b0; i_en = 1'b1;
    endtask

    task automatic do_clear();
        i_clear = 1'b1;
        tick(1'b0, 32'h0, 1'b0, 1'b0);
        i_clear = 1'b0;
    endtask

    task automatic test_reset();
        if (o_snap_vld !== 1'b0) begin errors++; $display("FAIL reset_snap_vld got %0h exp 0", o_snap_vld); end
        checks++;
        if (o_halt !== 1'b0) begin errors++; $display("FAIL reset_halt got %0h exp 0", o_halt); end
        checks++;
        if (o_halt_pc !== 32'h0) begin errors++; $display("FAIL reset_halt_pc got %0h exp 0", o_halt_pc); end
        checks++;
        for (int s = 0; s < 8; s++) begin
            i_rd_sel = 3'(s); #1;
            if (o_rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd sel=%0d got %0h exp 0", s, o_rd_data); end
            checks++;
        end
    endtask

    task automatic test_basic();
        logic [31:0] exp [5] = '{32'd10, 32'd5, 32'd0, 32'd0, 32'd5};
        i_en = 1'b1;
        for (int c = 0; c < 10; c++) tick((c % 2) == 0, 32'(c * 4), 1'b0, 1'b0);
        snapshot();
        if (o_snap_vld !== 1'b1) begin errors++; $display("FAIL basic_snap_vld got %0h exp 1", o_snap_vld); end
        checks++;
        for (int s = 0; s < 5; s++) begin
            i_rd_sel = 3'(s); #1;
            if (o_rd_data !== exp[s]) begin errors++; $display("FAIL basic_rd sel=%0d got %0d exp %0d", s, o_rd_data, exp[s]); end
            checks++;
        end
        tick(1'b0, 32'h0, 1'b0, 1'b0);
        if (o_snap_vld !== 1'b0) begin errors++; $display("FAIL basic_snap_pulse got %0h exp 0", o_snap_vld); end
        checks++;
    endtask

    task automatic test_halt();
        logic [31:0] exp [5] = '{32'd4, 32'd3, 32'd1, 32'd1, 32'd1};
        do_clear();
        tick(1'b1, 32'h40, 1'b1, 1'b0);
        tick(1'b1, 32'h40, 1'b0, 1'b0);
        tick(1'b0, 32'h40, 1'b0, 1'b1);
        if (o_halt !== 1'b0) begin errors++; $display("FAIL halt_early got %0h exp 0", o_halt); end
        checks++;
        tick(1'b1, 32'h40, 1'b0, 1'b0);
        if (o_halt !== 1'b1) begin errors++; $display("FAIL halt_rise got %0h exp 1", o_halt); end
        checks++;
        if (o_halt_pc !== 32'h40) begin errors++; $display("FAIL halt_pc got %0h exp 40", o_halt_pc); end
        checks++;
        for (int c = 0; c < 3; c++) tick(1'b1, 32'h80, 1'b1, 1'b1);
        snapshot();
        for (int s = 0; s < 5; s++) begin
            i_rd_sel = 3'(s); #1;
            if (o_rd_data !== exp[s]) begin errors++; $display("FAIL halt_frozen sel=%0d got %0d exp %0d", s, o_rd_data, exp[s]); end
            checks++;
        end
        i_rd_sel = 3'd5; #1;
        if (o_rd_data !== 32'h40) begin errors++; $display("FAIL halt_rd5 got %0h exp 40", o_rd_data); end
        checks++;
    endtask

    task automatic test_broken_run();
        do_clear();
        if (o_halt !== 1'b0) begin errors++; $display("FAIL clear_from_halt got %0h exp 0", o_halt); end
        checks++;
        tick(1'b1, 32'h40, 1'b0, 1'b0);
        tick(1'b1, 32'h44, 1'b0, 1'b0);
        tick(1'b1, 32'h40, 1'b0, 1'b0);
        tick(1'b1, 32'h40, 1'b0, 1'b0);
        if (o_halt !== 1'b0) begin errors++; $display("FAIL broken_no_halt got %0h exp 0", o_halt); end
        checks++;
        tick(1'b1, 32'h40, 1'b0, 1'b0);
        if (o_halt !== 1'b1) begin errors++; $display("FAIL broken_rep2_then_halt got %0h exp 1", o_halt); end
        checks++;
    endtask

    task automatic test_clear_snap();
        do_clear();
        for (int c = 0; c < 7; c++) tick(1'b1, 32'h100 + 32'(c * 4), 1'b0, 1'b0);
        i_clear = 1'b1; i_snap_req = 1'b1;
        tick(1'b1, 32'h300, 1'b0, 1'b0);
        i_clear = 1'b0; i_snap_req = 1'b0;
        if (o_snap_vld !== 1'b1) begin errors++; $display("FAIL clrsnap_vld got %0h exp 1", o_snap_vld); end
        checks++;
        i_rd_sel = 3'd1; #1;
        if (o_rd_data !== 32'd7) begin errors++; $display("FAIL clrsnap_ret got %0d exp 7", o_rd_data); end
        checks++;
        i_rd_sel = 3'd5; #1;
        if (o_rd_data !== 32'h40) begin errors++; $display("FAIL clrsnap_halt_pc_kept got %0h exp 40", o_rd_data); end
        checks++;
        if (o_halt !== 1'b0) begin errors++; $display("FAIL clrsnap_halt got %0h exp 0", o_halt); end
        checks++;
        snapshot();
        i_rd_sel = 3'd1; #1;
        if (o_rd_data !== 32'd0) begin errors++; $display("FAIL clrsnap_live_ret got %0d exp 0", o_rd_data); end
        checks++;
    endtask

    task automatic test_enable();
        do_clear();
        tick(1'b1, 32'h200, 1'b0, 1'b0);
        tick(1'b1, 32'h204, 1'b0, 1'b0);
        i_en = 1'b0;
        for (int c = 0; c < 5; c++) tick(1'b1, 32'h208, 1'b0, 1'b1);
        snapshot();
        if (o_snap_vld !== 1'b1) begin errors++; $display("FAIL en_snap_vld got %0h exp 1", o_snap_vld); end
        checks++;
        i_rd_sel = 3'd0; #1;
        if (o_rd_data !== 32'd2) begin errors++; $display("FAIL en_cyc got %0d exp 2", o_rd_data); end
        checks++;
        i_rd_sel = 3'd1; #1;
        if (o_rd_data !== 32'd2) begin errors++; $display("FAIL en_ret got %0d exp 2", o_rd_data); end
        checks++;
        i_rd_sel = 3'd3; #1;
        if (o_rd_data !== 32'd0) begin errors++; $display("FAIL en_mis got %0d exp 0", o_rd_data); end
        checks++;
    endtask

    task automatic test_back_to_back();
        do_clear();
        i_snap_req = 1'b1; i_rd_sel = 3'd0;
        for (int c = 0; c < 3; c++) begin
            tick(1'b0, 32'h0, 1'b0, 1'b0);
            if (o_snap_vld !== 1'b1) begin errors++; $display("FAIL b2b_vld c=%0d got %0h exp 1", c, o_snap_vld); end
            checks++;
            if (o_rd_data !== 32'(c)) begin errors++; $display("FAIL b2b_cyc c=%0d got %0d exp %0d", c, o_rd_data, c); end
            checks++;
        end
        i_snap_req = 1'b0;
    endtask

    task automatic test_saturate();
        do_clear();
        for (int c = 0; c < 300; c++) tick(1'b1, 32'h1000 + 32'(c * 4), 1'b0, 1'b0);
        snapshot();
        i_rd_sel = 3'd1; #1;
        if (rd_data8 !== 8'd255) begin errors++; $display("FAIL sat8_ret got %0d exp 255", rd_data8); end
        checks++;
        if (o_rd_data !== 32'd300) begin errors++; $display("FAIL sat32_ret got %0d exp 300", o_rd_data); end
        checks++;
        i_rd_sel = 3'd0; #1;
        if (rd_data8 !== 8'd255) begin errors++; $display("FAIL sat8_cyc got %0d exp 255", rd_data8); end
        checks++;
    endtask

    task automatic test_async_reset();
        do_clear();
        for (int c = 0; c < 3; c++) tick(1'b1, 32'h60, 1'b0, 1'b0);
        i_snap_req = 1'b1;
        tick(1'b0, 32'h0, 1'b0, 1'b0);
        i_snap_req = 1'b0;
        if (o_halt !== 1'b1 || o_snap_vld !== 1'b1) begin
            errors++; $display("FAIL pre_reset halt=%0h vld=%0h exp 1 1", o_halt, o_snap_vld);
        end
        checks++;
        #2 i_reset = 1'b0; #1;
        i_rd_sel = 3'd1; #1;
        if (o_halt !== 1'b0 || o_snap_vld !== 1'b0 || o_halt_pc !== 32'h0 || o_rd_data !== 32'h0) begin
            errors++; $display("FAIL async_reset halt=%0h vld=%0h pc=%0h rd=%0h exp 0 0 0 0", o_halt, o_snap_vld, o_halt_pc, o_rd_data);
        end
        checks++;
        @(negedge i_clk);
        i_reset = 1'b1;
        tick(1'b0, 32'h0, 1'b0, 1'b0);
        if (o_snap_vld !== 1'b0 || o_halt !== 1'b0) begin
            errors++; $display("FAIL post_reset vld=%0h halt=%0h exp 0 0", o_snap_vld, o_halt);
        end
        checks++;
    endtask

    initial begin
        repeat (2) @(negedge i_clk);
        test_reset();
        i_reset = 1'b1;
        test_basic();
        test_halt();
        test_broken_run();
        test_clear_snap();
        test_enable();
        test_back_to_back();
        test_saturate();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
